bsg_axil_nto1_arbiter: RTL and testbench
========================================

Name: bsg_axil_nto1_arbiter

Overview:
- Merges num_s_p independent AXI4-Lite client (slave-side) ports onto one AXI4-Lite master port.
- Write and read paths are arbitrated by two independent engines.
- Generalises the fixed multi-port AXI-lite plumbing of the zynq top level into a channel-count-parametrised, arbitrated, registered block. Typical use: BP MMIO and host shell sharing one m01-style peripheral bus.
- One transaction in flight per engine. Requests are registered on acceptance. Responses are routed back to the granted client.

Parameters:
- num_s_p, 3, number of client ports (>=1)
- addr_width_p, 32, AXI-lite address width
- data_width_p, 32, AXI-lite data width (multiple of 8)
- rr_p, 1, 1 = round-robin arbitration; 0 = fixed priority (lowest index wins)

Ports:
Clock and reset:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset

Client ports (per-port fields packed, port k at slice k):
- s_awaddr_i  in  num_s_p*addr_width_p  write address
- s_awprot_i  in  num_s_p*3  write prot
- s_awvalid_i  in  num_s_p  write address valid
- s_awready_o  out  num_s_p  write address ready
- s_wdata_i  in  num_s_p*data_width_p  write data
- s_wstrb_i  in  num_s_p*(data_width_p/8)  write strobe
- s_wvalid_i  in  num_s_p  write data valid
- s_wready_o  out  num_s_p  write data ready
- s_bresp_o  out  num_s_p*2  write response
- s_bvalid_o  out  num_s_p  write response valid
- s_bready_i  in  num_s_p  write response ready
- s_araddr_i  in  num_s_p*addr_width_p  read address
- s_arprot_i  in  num_s_p*3  read prot
- s_arvalid_i  in  num_s_p  read address valid
- s_arready_o  out  num_s_p  read address ready
- s_rdata_o  out  num_s_p*data_width_p  read data
- s_rresp_o  out  num_s_p*2  read response
- s_rvalid_o  out  num_s_p  read data valid
- s_rready_i  in  num_s_p  read data ready

Master port:
- m_awaddr_o  out  addr_width_p
- m_awprot_o  out  3
- m_awvalid_o  out  1
- m_awready_i  in  1
- m_wdata_o  out  data_width_p
- m_wstrb_o  out  data_width_p/8
- m_wvalid_o  out  1
- m_wready_i  in  1
- m_bresp_i  in  2
- m_bvalid_i  in  1
- m_bready_o  out  1
- m_araddr_o  out  addr_width_p
- m_arprot_o  out  3
- m_arvalid_o  out  1
- m_arready_i  in  1
- m_rdata_i  in  data_width_p
- m_rresp_i  in  2
- m_rvalid_i  in  1
- m_rready_o  out  1

Behaviour:
Reset:
- All valid/ready outputs are 0 during and after reset until the engine is in IDLE.
- Both engines reset to IDLE; RR pointers reset to num_s_p-1, so port 0 wins first.
- Reset mid-transaction abandons it with no response to the client.

Write engine, states IDLE -> SEND -> RESP -> IDLE:
- IDLE: a port is eligible only if awvalid[k] & wvalid[k]; the arbiter picks g.
  - Same cycle: s_awready_o[g] = s_wready_o[g] = 1 (combinational grant).
  - awaddr, awprot, wdata, wstrb are latched; state goes to SEND.
  - No other port sees ready.
- SEND:
  - m_awvalid_o and m_wvalid_o are each asserted from the cycle after grant.
  - Each drops independently after its own handshake, tracked by aw_done/w_done flags.
  - Go to RESP when both are done; simultaneous handshake in one cycle is legal.
- RESP:
  - s_bvalid_o[g] = m_bvalid_i, s_bresp_o[g] = m_bresp_i, m_bready_o = s_bready_i[g].
  - Return to IDLE on m_bvalid_i & s_bready_i[g].
  - The next grant can occur no earlier than the following cycle.
- Minimum occupancy: 3 cycles per write.

Read engine, states IDLE -> ADDR -> DATA -> IDLE:
- Mirrors the write engine, using arvalid.
- s_rdata_o[g] and s_rresp_o[g] come from the master port; non-granted slices are 0.

Arbitration:
- rr_p=1: search starts at last_grant+1 modulo num_s_p; the pointer updates to g on grant.
- rr_p=0: lowest eligible index wins.
- Read and write pointers are independent.

Independence and ordering:
- Read and write engines may be active simultaneously, including for the same client.
- The block adds no read/write ordering guarantee.

Hold and errors:
- A client holding valid without a grant keeps waiting; no starvation under rr_p=1 (bounded by num_s_p grants).
- Responses (SLVERR/DECERR) pass through unmodified.
- num_s_p=1: the arbiter degenerates to a constant grant; the latency above is unchanged.

Test Plan:
1. Single write, port 1: awaddr=0x40, wdata=0xDEADBEEF, wstrb=0xF.
   - Response: s_awready_o=3'b010 at grant.
   - m_awvalid_o/m_wvalid_o with 0x40/0xDEADBEEF next cycle.
   - m_bresp_i=0 is returned on s_bvalid_o[1] only.
2. RR fairness: ports 0, 1, 2 all hold reads continuously (araddr 0x0/0x4/0x8), master always ready.
   - Master sees araddr 0x0, 0x4, 0x8, 0x0 in that order.
   - Under rr_p=0, the master sees 0x0 repeatedly.
3. Split write handshake: m_awready_i high on the first SEND cycle, m_wready_i delayed 4 cycles.
   - m_awvalid_o is asserted for exactly 1 cycle; m_wvalid_o stays high until accepted.
   - No bready before RESP.
4. Concurrent read and write: port 0 write to 0x10 and port 2 read of 0x20 in the same cycle.
   - Both grants occur in that cycle.
   - s_rdata_o[2] = m_rdata_i = 0x1234 while the write is still in RESP.
5. Backpressured response: m_bvalid_i=1, m_bresp_i=2'b10, s_bready_i[0]=0 for 3 cycles.
   - s_bvalid_o[0] is held with bresp 2'b10.
   - No new write grant until the handshake completes.
6. Reset asserted while in DATA: all s_/m_ valids are 0 the cycle after.
   - The next read request is granted to port 0 (pointer reset).

Source files
------------

// File: rtl/bsg_axil_nto1_arbiter.sv
// N-to-1 AXI4-Lite arbiter: independent write and read engines, one transaction
// in flight each, requests registered on grant, responses routed to the granted port.

module bsg_axil_nto1_rr_arb #(
  parameter int num_p   = 3,
  parameter int rr_p    = 1,
  parameter int idx_w_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [num_p-1:0]   req_i,
  input  logic               yumi_i,
  output logic               v_o,
  output logic [idx_w_p-1:0] idx_o
);
  logic [idx_w_p-1:0] last_r, cand;

  // Fixed priority is round-robin with the pointer pinned to the last port.
  always_comb begin
    v_o   = 1'b0;
    idx_o = '0;
    cand  = (rr_p != 0) ? last_r : idx_w_p'(num_p-1);
    for (int i = 0; i < num_p; i++) begin
      cand = (cand == idx_w_p'(num_p-1)) ? '0 : cand + 1'b1;
      if (!v_o && req_i[cand]) begin
        v_o   = 1'b1;
        idx_o = cand;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)     last_r <= idx_w_p'(num_p-1);
    else if (yumi_i) last_r <= idx_o;
  end
endmodule

module bsg_axil_nto1_arbiter #(
  parameter int num_s_p      = 3,
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32,
  parameter int rr_p         = 1
) (
  input  logic clk_i,
  input  logic reset_i,

  input  logic [num_s_p-1:0][addr_width_p-1:0]   s_awaddr_i,
  input  logic [num_s_p-1:0][2:0]                s_awprot_i,
  input  logic [num_s_p-1:0]                     s_awvalid_i,
  output logic [num_s_p-1:0]                     s_awready_o,
  input  logic [num_s_p-1:0][data_width_p-1:0]   s_wdata_i,
  input  logic [num_s_p-1:0][data_width_p/8-1:0] s_wstrb_i,
  input  logic [num_s_p-1:0]                     s_wvalid_i,
  output logic [num_s_p-1:0]                     s_wready_o,
  output logic [num_s_p-1:0][1:0]                s_bresp_o,
  output logic [num_s_p-1:0]                     s_bvalid_o,
  input  logic [num_s_p-1:0]                     s_bready_i,
  input  logic [num_s_p-1:0][addr_width_p-1:0]   s_araddr_i,
  input  logic [num_s_p-1:0][2:0]                s_arprot_i,
  input  logic [num_s_p-1:0]                     s_arvalid_i,
  output logic [num_s_p-1:0]                     s_arready_o,
  output logic [num_s_p-1:0][data_width_p-1:0]   s_rdata_o,
  output logic [num_s_p-1:0][1:0]                s_rresp_o,
  output logic [num_s_p-1:0]                     s_rvalid_o,
  input  logic [num_s_p-1:0]                     s_rready_i,

  output logic [addr_width_p-1:0]   m_awaddr_o,
  output logic [2:0]                m_awprot_o,
  output logic                      m_awvalid_o,
  input  logic                      m_awready_i,
  output logic [data_width_p-1:0]   m_wdata_o,
  output logic [data_width_p/8-1:0] m_wstrb_o,
  output logic                      m_wvalid_o,
  input  logic                      m_wready_i,
  input  logic [1:0]                m_bresp_i,
  input  logic                      m_bvalid_i,
  output logic                      m_bready_o,
  output logic [addr_width_p-1:0]   m_araddr_o,
  output logic [2:0]                m_arprot_o,
  output logic                      m_arvalid_o,
  input  logic                      m_arready_i,
  input  logic [data_width_p-1:0]   m_rdata_i,
  input  logic [1:0]                m_rresp_i,
  input  logic                      m_rvalid_i,
  output logic                      m_rready_o
);
  localparam int idx_w_lp = (num_s_p > 1) ? $clog2(num_s_p) : 1;

  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

  w_state_e w_state;
  r_state_e r_state;
  logic [idx_w_lp-1:0] w_sel, r_sel, w_gnt_idx, r_gnt_idx;
  logic w_gnt_v, r_gnt_v, w_take, r_take, w_resp, r_data;

  assign w_take = (w_state == W_IDLE) & w_gnt_v & ~reset_i;
  assign r_take = (r_state == R_IDLE) & r_gnt_v & ~reset_i;
  assign w_resp = (w_state == W_RESP);
  assign r_data = (r_state == R_DATA);

  bsg_axil_nto1_rr_arb #(.num_p(num_s_p), .rr_p(rr_p), .idx_w_p(idx_w_lp)) w_arb (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(s_awvalid_i & s_wvalid_i),
    .yumi_i(w_take), .v_o(w_gnt_v), .idx_o(w_gnt_idx));

  bsg_axil_nto1_rr_arb #(.num_p(num_s_p), .rr_p(rr_p), .idx_w_p(idx_w_lp)) r_arb (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(s_arvalid_i),
    .yumi_i(r_take), .v_o(r_gnt_v), .idx_o(r_gnt_idx));

  for (genvar k = 0; k < num_s_p; k++) begin : port
    logic w_own, r_own;
    assign w_own          = w_resp & (w_sel == idx_w_lp'(k));
    assign r_own          = r_data & (r_sel == idx_w_lp'(k));
    assign s_awready_o[k] = w_take & (w_gnt_idx == idx_w_lp'(k));
    assign s_wready_o[k]  = s_awready_o[k];
    assign s_bvalid_o[k]  = w_own & m_bvalid_i;
    assign s_bresp_o[k]   = w_own ? m_bresp_i : 2'b00;
    assign s_arready_o[k] = r_take & (r_gnt_idx == idx_w_lp'(k));
    assign s_rvalid_o[k]  = r_own & m_rvalid_i;
    assign s_rdata_o[k]   = r_own ? m_rdata_i : '0;
    assign s_rresp_o[k]   = r_own ? m_rresp_i : 2'b00;
  end

  assign m_bready_o = w_resp & s_bready_i[w_sel];
  assign m_rready_o = r_data & s_rready_i[r_sel];

  // AW and W are released independently; the pending flags double as the valids.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      w_state     <= W_IDLE;
      w_sel       <= '0;
      m_awvalid_o <= 1'b0;
      m_wvalid_o  <= 1'b0;
      m_awaddr_o  <= '0;
      m_awprot_o  <= '0;
      m_wdata_o   <= '0;
      m_wstrb_o   <= '0;
    end else begin
      unique case (w_state)
        W_IDLE: if (w_gnt_v) begin
          w_sel       <= w_gnt_idx;
          m_awaddr_o  <= s_awaddr_i[w_gnt_idx];
          m_awprot_o  <= s_awprot_i[w_gnt_idx];
          m_wdata_o   <= s_wdata_i[w_gnt_idx];
          m_wstrb_o   <= s_wstrb_i[w_gnt_idx];
          m_awvalid_o <= 1'b1;
          m_wvalid_o  <= 1'b1;
          w_state     <= W_SEND;
        end
        W_SEND: begin
          if (m_awready_i) m_awvalid_o <= 1'b0;
          if (m_wready_i)  m_wvalid_o  <= 1'b0;
          if ((~m_awvalid_o | m_awready_i) & (~m_wvalid_o | m_wready_i))
            w_state <= W_RESP;
        end
        W_RESP: if (m_bvalid_i & s_bready_i[w_sel]) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= R_IDLE;
      r_sel       <= '0;
      m_arvalid_o <= 1'b0;
      m_araddr_o  <= '0;
      m_arprot_o  <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: if (r_gnt_v) begin
          r_sel       <= r_gnt_idx;
          m_araddr_o  <= s_araddr_i[r_gnt_idx];
          m_arprot_o  <= s_arprot_i[r_gnt_idx];
          m_arvalid_o <= 1'b1;
          r_state     <= R_ADDR;
        end
        R_ADDR: if (m_arready_i) begin
          m_arvalid_o <= 1'b0;
          r_state     <= R_DATA;
        end
        R_DATA: if (m_rvalid_i & s_rready_i[r_sel]) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bsg_axil_nto1_arbiter.sv
// Scoreboarded bench for bsg_axil_nto1_arbiter: a round-robin instance is fully checked,
// a fixed-priority twin on the same inputs is checked for its read address order.

module tb_bsg_axil_nto1_arbiter;
  localparam int N = 3, AW = 32, DW = 32;

  typedef struct { int port; logic [63:0] data; } rsp_t;

  logic clk = 1'b0, rst;
  always #5 clk = ~clk;

  logic [N-1:0][AW-1:0] s_awaddr, s_araddr;
  logic [N-1:0][2:0]    s_awprot, s_arprot;
  logic [N-1:0][DW-1:0] s_wdata;
  logic [N-1:0][3:0]    s_wstrb;
  logic [N-1:0]         s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic [AW-1:0] m_awaddr, m_araddr, f_awaddr, f_araddr;
  logic [2:0]    m_awprot, m_arprot, f_awprot, f_arprot;
  logic [DW-1:0] m_wdata, f_wdata, m_rdata;
  logic [3:0]    m_wstrb, f_wstrb;
  logic [1:0]    m_bresp, m_rresp;
  logic m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic f_awvalid, f_wvalid, f_bready, f_arvalid, f_rready;
  logic m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  logic [N-1:0]         s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [N-1:0]         f_s_awready, f_s_wready, f_s_bvalid, f_s_arready, f_s_rvalid;
  logic [N-1:0][1:0]    s_bresp, s_rresp, f_s_bresp, f_s_rresp;
  logic [N-1:0][DW-1:0] s_rdata, f_s_rdata;

  bsg_axil_nto1_arbiter #(.num_s_p(N), .addr_width_p(AW), .data_width_p(DW), .rr_p(1)) dut (
    .clk_i(clk), .reset_i(rst),
    .s_awaddr_i(s_awaddr), .s_awprot_i(s_awprot), .s_awvalid_i(s_awvalid), .s_awready_o(s_awready),
    .s_wdata_i(s_wdata), .s_wstrb_i(s_wstrb), .s_wvalid_i(s_wvalid), .s_wready_o(s_wready),
    .s_bresp_o(s_bresp), .s_bvalid_o(s_bvalid), .s_bready_i(s_bready),
    .s_araddr_i(s_araddr), .s_arprot_i(s_arprot), .s_arvalid_i(s_arvalid), .s_arready_o(s_arready),
    .s_rdata_o(s_rdata), .s_rresp_o(s_rresp), .s_rvalid_o(s_rvalid), .s_rready_i(s_rready),
    .m_awaddr_o(m_awaddr), .m_awprot_o(m_awprot), .m_awvalid_o(m_awvalid), .m_awready_i(m_awready),
    .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb), .m_wvalid_o(m_wvalid), .m_wready_i(m_wready),
    .m_bresp_i(m_bresp), .m_bvalid_i(m_bvalid), .m_bready_o(m_bready),
    .m_araddr_o(m_araddr), .m_arprot_o(m_arprot), .m_arvalid_o(m_arvalid), .m_arready_i(m_arready),
    .m_rdata_i(m_rdata), .m_rresp_i(m_rresp), .m_rvalid_i(m_rvalid), .m_rready_o(m_rready));

  bsg_axil_nto1_arbiter #(.num_s_p(N), .addr_width_p(AW), .data_width_p(DW), .rr_p(0)) dut_fp (
    .clk_i(clk), .reset_i(rst),
    .s_awaddr_i(s_awaddr), .s_awprot_i(s_awprot), .s_awvalid_i(s_awvalid), .s_awready_o(f_s_awready),
    .s_wdata_i(s_wdata), .s_wstrb_i(s_wstrb), .s_wvalid_i(s_wvalid), .s_wready_o(f_s_wready),
    .s_bresp_o(f_s_bresp), .s_bvalid_o(f_s_bvalid), .s_bready_i(s_bready),
    .s_araddr_i(s_araddr), .s_arprot_i(s_arprot), .s_arvalid_i(s_arvalid), .s_arready_o(f_s_arready),
    .s_rdata_o(f_s_rdata), .s_rresp_o(f_s_rresp), .s_rvalid_o(f_s_rvalid), .s_rready_i(s_rready),
    .m_awaddr_o(f_awaddr), .m_awprot_o(f_awprot), .m_awvalid_o(f_awvalid), .m_awready_i(m_awready),
    .m_wdata_o(f_wdata), .m_wstrb_o(f_wstrb), .m_wvalid_o(f_wvalid), .m_wready_i(m_wready),
    .m_bresp_i(m_bresp), .m_bvalid_i(m_bvalid), .m_bready_o(f_bready),
    .m_araddr_o(f_araddr), .m_arprot_o(f_arprot), .m_arvalid_o(f_arvalid), .m_arready_i(m_arready),
    .m_rdata_i(m_rdata), .m_rresp_i(m_rresp), .m_rvalid_i(m_rvalid), .m_rready_o(f_rready));

  int checks = 0, failures = 0;
  logic [63:0] exp_aw[$], exp_w[$], exp_ar[$];
  rsp_t exp_b[$], exp_r[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    s_awaddr = '0; s_araddr = '0; s_awprot = '0; s_arprot = '0; s_wdata = '0; s_wstrb = '0;
    s_awvalid = '0; s_wvalid = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = '0;
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_out", 64'({s_awready, s_wready, s_bvalid, s_arready, s_rvalid,
                        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 64'd0);
    cyc();
    rst = 1'b0;
  endtask

  task automatic push_w(input int port, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] data, input logic [1:0] resp);
    exp_aw.push_back(64'(addr));
    exp_w.push_back(64'({strb, data}));
    exp_b.push_back('{port, 64'(resp)});
  endtask

  task automatic drive_w(input int port, input logic [31:0] addr, input logic [3:0] strb,
                         input logic [31:0] data);
    s_awaddr[port] = addr; s_wdata[port] = data; s_wstrb[port] = strb;
    s_awvalid[port] = 1'b1; s_wvalid[port] = 1'b1;
  endtask

  // Master-side and client-side handshake monitor; pops the scoreboard.
  always @(negedge clk) begin : mon
    rsp_t e;
    if (!rst) begin
      if (m_awvalid && m_awready) begin
        if (exp_aw.size() == 0) chk("aw_extra", 64'd1, 64'd0);
        else chk("aw_addr", 64'(m_awaddr), exp_aw.pop_front());
      end
      if (m_wvalid && m_wready) begin
        if (exp_w.size() == 0) chk("w_extra", 64'd1, 64'd0);
        else chk("w_strb_data", 64'({m_wstrb, m_wdata}), exp_w.pop_front());
      end
      if (m_arvalid && m_arready) begin
        if (exp_ar.size() == 0) chk("ar_extra", 64'd1, 64'd0);
        else chk("ar_addr", 64'(m_araddr), exp_ar.pop_front());
      end
      for (int k = 0; k < N; k++) begin
        if (s_bvalid[k] && s_bready[k]) begin
          if (exp_b.size() == 0) chk("b_extra", 64'd1, 64'd0);
          else begin
            e = exp_b.pop_front();
            chk("b_port", 64'(k), 64'(e.port));
            chk("b_resp", 64'(s_bresp[k]), e.data);
          end
        end
        if (s_rvalid[k] && s_rready[k]) begin
          if (exp_r.size() == 0) chk("r_extra", 64'd1, 64'd0);
          else begin
            e = exp_r.pop_front();
            chk("r_port", 64'(k), 64'(e.port));
            chk("r_data", 64'(s_rdata[k]), e.data);
          end
        end
      end
    end
  end

  initial begin
    int fp_cnt;
    rst = 1'b1;
    clear_inputs();

    // Single write from port 1
    do_reset();
    cyc();
    drive_w(1, 32'h40, 4'hF, 32'hDEADBEEF); s_awprot[1] = 3'b010;
    push_w(1, 32'h40, 4'hF, 32'hDEADBEEF, 2'b00);
    @(negedge clk);
    chk("t1_awready", 64'(s_awready), 64'(3'b010));
    chk("t1_wready", 64'(s_wready), 64'(3'b010));
    cyc();
    s_awvalid = '0; s_wvalid = '0; m_awready = 1; m_wready = 1;
    @(negedge clk);
    chk("t1_m_valids", 64'({m_awvalid, m_wvalid}), 64'(2'b11));
    chk("t1_awprot", 64'(m_awprot), 64'(3'b010));
    cyc();
    m_awready = 0; m_wready = 0; m_bvalid = 1; m_bresp = 2'b00; s_bready = 3'b010;
    @(negedge clk);
    chk("t1_bvalid", 64'(s_bvalid), 64'(3'b010));
    chk("t1_bready", 64'(m_bready), 64'd1);
    cyc();
    m_bvalid = 0; s_bready = '0;
    @(negedge clk);
    chk("t1_idle_bvalid", 64'(s_bvalid), 64'd0);

    // Round-robin fairness on reads, fixed-priority twin alongside
    do_reset();
    cyc();
    s_araddr[0] = 32'h0; s_araddr[1] = 32'h4; s_araddr[2] = 32'h8; s_arvalid = 3'b111;
    m_arready = 1; m_rvalid = 1; m_rdata = 32'h900D; s_rready = 3'b111;
    exp_ar.push_back(64'h0); exp_ar.push_back(64'h4); exp_ar.push_back(64'h8); exp_ar.push_back(64'h0);
    exp_r.push_back('{0, 64'h900D}); exp_r.push_back('{1, 64'h900D});
    exp_r.push_back('{2, 64'h900D}); exp_r.push_back('{0, 64'h900D});
    fp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (f_arvalid) begin
        fp_cnt++;
        chk("t2_fp_araddr", 64'(f_araddr), 64'h0);
      end
      cyc();
    end
    s_arvalid = '0; m_arready = 0; m_rvalid = 0; s_rready = '0;
    chk("t2_fp_count", 64'(fp_cnt), 64'd4);
    chk("t2_ar_drained", 64'(exp_ar.size()), 64'd0);

    // Split write handshake: AW accepted at once, W after 4 SEND cycles
    do_reset();
    cyc();
    drive_w(2, 32'h80, 4'hC, 32'h55AA); s_bready = 3'b100;
    push_w(2, 32'h80, 4'hC, 32'h55AA, 2'b00);
    @(negedge clk);
    chk("t3_awready", 64'(s_awready), 64'(3'b100));
    cyc();
    s_awvalid = '0; s_wvalid = '0; m_awready = 1;
    @(negedge clk);
    chk("t3_send1", 64'({m_awvalid, m_wvalid, m_bready}), 64'(3'b110));
    cyc();
    m_awready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_wait", 64'({m_awvalid, m_wvalid, m_bready}), 64'(3'b010));
      cyc();
    end
    m_wready = 1;
    @(negedge clk);
    chk("t3_w_last", 64'({m_awvalid, m_wvalid, m_bready}), 64'(3'b010));
    cyc();
    m_wready = 0; m_bvalid = 1; m_bresp = 2'b00;
    @(negedge clk);
    chk("t3_resp", 64'({s_bvalid, m_bready}), 64'({3'b100, 1'b1}));
    cyc();
    m_bvalid = 0; s_bready = '0;

    // Concurrent write (port 0) and read (port 2)
    do_reset();
    cyc();
    drive_w(0, 32'h10, 4'h3, 32'hCAFE);
    s_araddr[2] = 32'h20; s_arvalid[2] = 1'b1;
    push_w(0, 32'h10, 4'h3, 32'hCAFE, 2'b00);
    exp_ar.push_back(64'h20);
    exp_r.push_back('{2, 64'h1234});
    @(negedge clk);
    chk("t4_awready", 64'(s_awready), 64'(3'b001));
    chk("t4_arready", 64'(s_arready), 64'(3'b100));
    cyc();
    s_awvalid = '0; s_wvalid = '0; s_arvalid = '0;
    m_awready = 1; m_wready = 1; m_arready = 1;
    @(negedge clk);
    cyc();
    m_awready = 0; m_wready = 0; m_arready = 0;
    m_rvalid = 1; m_rdata = 32'h1234; s_rready = 3'b100;
    @(negedge clk);
    chk("t4_rdata2", 64'(s_rdata[2]), 64'h1234);
    chk("t4_rdata0", 64'(s_rdata[0]), 64'h0);
    chk("t4_rvalid", 64'(s_rvalid), 64'(3'b100));
    chk("t4_no_bvalid", 64'(s_bvalid), 64'd0);
    cyc();
    m_rvalid = 0; s_rready = '0; m_bvalid = 1; s_bready = 3'b001;
    @(negedge clk);
    cyc();
    m_bvalid = 0; s_bready = '0;

    // Backpressured SLVERR response, port 1 waiting behind it
    do_reset();
    cyc();
    drive_w(0, 32'h30, 4'hF, 32'h1);
    push_w(0, 32'h30, 4'hF, 32'h1, 2'b10);
    @(negedge clk);
    chk("t5_awready0", 64'(s_awready), 64'(3'b001));
    cyc();
    s_awvalid = '0; s_wvalid = '0;
    drive_w(1, 32'h34, 4'hF, 32'h2);
    push_w(1, 32'h34, 4'hF, 32'h2, 2'b00);
    m_awready = 1; m_wready = 1;
    @(negedge clk);
    chk("t5_send_noawready", 64'(s_awready), 64'd0);
    cyc();
    m_awready = 0; m_wready = 0; m_bvalid = 1; m_bresp = 2'b10; s_bready = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_hold_bvalid", 64'(s_bvalid), 64'(3'b001));
      chk("t5_hold_bresp", 64'(s_bresp[0]), 64'(2'b10));
      chk("t5_hold_nogrant", 64'({s_awready, m_bready}), 64'd0);
      cyc();
    end
    s_bready = 3'b001;
    @(negedge clk);
    chk("t5_hs_nogrant", 64'(s_awready), 64'd0);
    cyc();
    m_bvalid = 0; m_bresp = 2'b00; s_bready = '0;
    @(negedge clk);
    chk("t5_next_grant", 64'(s_awready), 64'(3'b010));
    cyc();
    s_awvalid = '0; s_wvalid = '0; m_awready = 1; m_wready = 1;
    @(negedge clk);
    cyc();
    m_awready = 0; m_wready = 0; m_bvalid = 1; s_bready = 3'b010;
    @(negedge clk);
    cyc();
    m_bvalid = 0; s_bready = '0;

    // Reset while the read engine sits in DATA
    do_reset();
    cyc();
    s_araddr[0] = 32'h44; s_arvalid[0] = 1'b1;
    exp_ar.push_back(64'h44);
    @(negedge clk);
    chk("t6_arready", 64'(s_arready), 64'(3'b001));
    cyc();
    s_arvalid = '0; m_arready = 1;
    @(negedge clk);
    cyc();
    m_arready = 0;
    @(negedge clk);
    chk("t6_in_data", 64'(m_rready), 64'd0);
    cyc();
    rst = 1'b1; m_rvalid = 1; m_rdata = 32'hBAD; s_rready = 3'b001; s_bready = 3'b111;
    cyc();
    @(negedge clk);
    chk("t6_rst_valids", 64'({s_rvalid, s_bvalid, s_arready, s_awready,
                              m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}), 64'd0);
    cyc();
    rst = 1'b0; m_rvalid = 0; s_rready = '0; s_bready = '0;
    s_araddr[0] = 32'h48; s_araddr[1] = 32'h4C; s_arvalid = 3'b011;
    exp_ar.push_back(64'h48);
    exp_r.push_back('{0, 64'h77});
    @(negedge clk);
    chk("t6_ptr_reset", 64'(s_arready), 64'(3'b001));
    cyc();
    s_arvalid = '0; m_arready = 1;
    @(negedge clk);
    cyc();
    m_arready = 0; m_rvalid = 1; m_rdata = 32'h77; s_rready = 3'b001;
    @(negedge clk);
    cyc();
    m_rvalid = 0; s_rready = '0;
    @(negedge clk);

    chk("sb_drained", 64'(exp_aw.size() + exp_w.size() + exp_ar.size() + exp_b.size() + exp_r.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
